hazard_unit: RTL and testbench
==============================

# hazard_unit

Load-use hazard detection unit for the 5-stage pipelined RV32 core, sitting between the IF/ID and ID/EX pipeline registers. It detects when the instruction in ID reads a register that the load in EX is about to write. On detection it freezes the PC and the IF/ID register, and selects the bubble (zeroed control) path into ID/EX. A small clocked block also keeps hazard statistics for debug and performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter (minimum 1).

Ports:
- clk  input  1  core clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- RS1_IF_ID  input  5  rs1 field of the instruction in IF/ID.
- RS2_IF_ID  input  5  rs2 field of the instruction in IF/ID.
- RD_ID_EX  input  5  rd field of the instruction in ID/EX.
- memread_ID_EX  input  1  MemRead control of the ID/EX instruction (load in EX).
- PCstall  output  1  1 = hold PC this cycle.
- IFIDwrite  output  1  1 = hold IF/ID (write suppressed); active-high hold despite the name.
- MUXsel  output  1  1 = drive zeroed control (bubble) into ID/EX.
- stall_prev  output  1  registered copy of the hazard signal from the previous cycle.
- stall_cnt  output  CNT_W  saturating count of stalled cycles (present only with HAZARD_STALL_CNT_EN).

## Operation
- hazard = memread_ID_EX & (RD_ID_EX != 0) & ((RD_ID_EX == RS1_IF_ID) | (RD_ID_EX == RS2_IF_ID)).
- PCstall = IFIDwrite = MUXsel = hazard. All three are identical, purely combinational, and independent of clk, rst_n and all state.
- x0 is never a hazard source: RD_ID_EX = 0 forces all three outputs to 0, even when RS1/RS2 are also 0.
- A match on rs1 alone, rs2 alone, or both gives the same single hazard.
- With memread_ID_EX = 0 the outputs are 0 regardless of register matches. ALU-to-ALU dependencies belong to the forwarding unit.
- No instruction-type qualification is performed: an rs2 field that is actually an immediate still triggers a stall. This false stall is conservative and accepted.
- stall_prev: flop that samples hazard on each rising clk.
- stall_cnt: on each rising clk where hazard = 1, increments by 1 and saturates at all-ones (no wrap).

## Timing
- Combinational path from inputs to PCstall/IFIDwrite/MUXsel, with zero cycles of latency. The outputs must settle within the same cycle so the PC and IF/ID enables are valid before the next edge.
- A single load-use produces exactly one stall cycle. On the next edge the load advances and the bubble enters ID/EX, with memread_ID_EX = 0, so hazard deasserts without any internal state.
- Reset values: stall_prev = 0 and stall_cnt = 0, applied immediately on rst_n low and independent of clk. The combinational outputs are unaffected by reset and track the inputs even while rst_n = 0.
- Reset asserted mid-stall clears the statistics only. It does not alter the current PCstall, IFIDwrite or MUXsel.
- Saturation: when stall_cnt = 2^CNT_W−1 and hazard = 1, stall_cnt holds its value.
- X on inputs must not be masked: outputs propagate X per standard operator semantics.

## Configuration
- HAZARD_STALL_CNT_EN defined: stall_cnt port and its counter logic are compiled in, behaving as described above.
- HAZARD_STALL_CNT_EN undefined: the stall_cnt port and counter are absent. stall_prev and the hazard outputs remain unchanged.

## Test plan
- RS1=1, RS2=2, RD=0, memread=0 -> PCstall=IFIDwrite=MUXsel=0.
- RS1=1, RS2=2, RD=1, memread=1 -> all three = 1 (rs1 match).
- RS1=1, RS2=2, RD=2, memread=1 -> all three = 1 (rs2 match).
- RS1=1, RS2=2, RD=1, memread=0 -> all three = 0. Then RD=0, RS1=0, memread=1 -> all three = 0 (x0 exclusion).
- Clocked: pulse rst_n low, then hold a hazard for 3 edges -> stall_prev=1 and stall_cnt=3. Drop hazard -> stall_prev=0 after one edge and stall_cnt holds 3. Assert rst_n low asynchronously -> both clear immediately.
- With CNT_W=2, hold hazard for 5 edges -> stall_cnt reaches 3 and holds (no wrap). With the macro undefined, the build has no stall_cnt port.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Load-use hazard bundle between the ID-stage register fields and the
// stall controls; master = pipeline side, slave = hazard_unit.
interface hazard_unit_if;
  logic [4:0] RS1_IF_ID;
  logic [4:0] RS2_IF_ID;
  logic [4:0] RD_ID_EX;
  logic       memread_ID_EX;
  logic       PCstall;
  logic       IFIDwrite;
  logic       MUXsel;
  logic       stall_prev;

  modport master (
    output RS1_IF_ID,
    output RS2_IF_ID,
    output RD_ID_EX,
    output memread_ID_EX,
    input  PCstall,
    input  IFIDwrite,
    input  MUXsel,
    input  stall_prev
  );

  modport slave (
    input  RS1_IF_ID,
    input  RS2_IF_ID,
    input  RD_ID_EX,
    input  memread_ID_EX,
    output PCstall,
    output IFIDwrite,
    output MUXsel,
    output stall_prev
  );
endinterface

// File: rtl/hazard_unit.sv
// Load-use hazard detection: freezes PC and IF/ID and bubbles ID/EX.
// Ports: clk, rst_n (async low), hz (hazard_unit_if.slave),
// stall_cnt [CNT_W] only when HAZARD_STALL_CNT_EN is defined.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_unit_if.slave     hz
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic hazard;

  // x0 never carries a dependency; rs2 is not qualified by opcode,
  // so an immediate aliasing rd gives a harmless extra stall.
  assign hazard = hz.memread_ID_EX
                & (hz.RD_ID_EX != 5'd0)
                & ((hz.RD_ID_EX == hz.RS1_IF_ID)
                 | (hz.RD_ID_EX == hz.RS2_IF_ID));

  assign hz.PCstall   = hazard;
  assign hz.IFIDwrite = hazard;
  assign hz.MUXsel    = hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz.stall_prev <= 1'b0;
    end else begin
      hz.stall_prev <= hazard;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: table vectors via a scoreboard
// queue plus clocked reset/statistics sequences.
module tb_hazard_unit;

  logic clk;
  logic rst_n;

  hazard_unit_if hz ();

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;
  hazard_unit_if hz2 ();

  assign hz2.RS1_IF_ID     = hz.RS1_IF_ID;
  assign hz2.RS2_IF_ID     = hz.RS2_IF_ID;
  assign hz2.RD_ID_EX      = hz.RD_ID_EX;
  assign hz2.memread_ID_EX = hz.memread_ID_EX;

  hazard_unit #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hz        (hz.slave),
    .stall_cnt (stall_cnt)
  );

  hazard_unit #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .hz        (hz2.slave),
    .stall_cnt (stall_cnt2)
  );
`else
  hazard_unit #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );
`endif

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       mr;
    logic       exp;
  } vec_t;

  vec_t   vecs [10];
  logic   sb [$];
  int     checks;
  int     errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr);
    hz.RS1_IF_ID     = rs1;
    hz.RS2_IF_ID     = rs2;
    hz.RD_ID_EX      = rd;
    hz.memread_ID_EX = mr;
  endtask

  task automatic cmp_outs(input string name);
    logic e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, ".PCstall"}, {31'd0, hz.PCstall}, {31'd0, e});
      chk({name, ".IFIDwrite"}, {31'd0, hz.IFIDwrite}, {31'd0, e});
      chk({name, ".MUXsel"}, {31'd0, hz.MUXsel}, {31'd0, e});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{5'd1,  5'd2,  5'd0,  1'b0, 1'b0};
    vecs[1] = '{5'd1,  5'd2,  5'd1,  1'b1, 1'b1};
    vecs[2] = '{5'd1,  5'd2,  5'd2,  1'b1, 1'b1};
    vecs[3] = '{5'd1,  5'd2,  5'd1,  1'b0, 1'b0};
    vecs[4] = '{5'd0,  5'd2,  5'd0,  1'b1, 1'b0};
    vecs[5] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0};
    vecs[6] = '{5'd7,  5'd7,  5'd7,  1'b1, 1'b1};
    vecs[7] = '{5'd3,  5'd4,  5'd31, 1'b1, 1'b0};
    vecs[8] = '{5'd31, 5'd9,  5'd31, 1'b1, 1'b1};
    vecs[9] = '{5'd5,  5'd30, 5'd30, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0);
    #3;
    chk("rst.stall_prev", {31'd0, hz.stall_prev}, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
    chk("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr);
      sb.push_back(vecs[i].exp);
      #1;
      cmp_outs($sformatf("vec%0d", i));
    end

    // hazard visible combinationally while held in reset
    drive(5'd1, 5'd2, 5'd1, 1'b1);
    sb.push_back(1'b1);
    #1;
    cmp_outs("in_reset");

    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("hold3.stall_prev", {31'd0, hz.stall_prev}, 32'd1);
`ifdef HAZARD_STALL_CNT_EN
    chk("hold3.stall_cnt", {16'd0, stall_cnt}, 32'd3);
    chk("hold3.stall_cnt2", {30'd0, stall_cnt2}, 32'd3);
`endif

    @(negedge clk);
    drive(5'd1, 5'd2, 5'd1, 1'b0);
    @(posedge clk);
    #1;
    chk("drop.stall_prev", {31'd0, hz.stall_prev}, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
    chk("drop.stall_cnt", {16'd0, stall_cnt}, 32'd3);
`endif

    @(negedge clk);
    drive(5'd1, 5'd2, 5'd2, 1'b1);
    @(posedge clk);
    #1;
    chk("re.stall_prev", {31'd0, hz.stall_prev}, 32'd1);
`ifdef HAZARD_STALL_CNT_EN
    chk("re.stall_cnt", {16'd0, stall_cnt}, 32'd4);
`endif

    // async reset mid-stall: statistics clear, stall outputs stay
    #2;
    rst_n = 1'b0;
    sb.push_back(1'b1);
    #1;
    chk("arst.stall_prev", {31'd0, hz.stall_prev}, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
    chk("arst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("arst.stall_cnt2", {30'd0, stall_cnt2}, 32'd0);
`endif
    cmp_outs("arst");

    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("sat.stall_prev", {31'd0, hz.stall_prev}, 32'd1);
`ifdef HAZARD_STALL_CNT_EN
    chk("sat.stall_cnt", {16'd0, stall_cnt}, 32'd5);
    chk("sat.stall_cnt2", {30'd0, stall_cnt2}, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
